sram_arbiter_65536x8: RTL and testbench

Two-port arbiter that shares one 65536x8 single-port synchronous SRAM between a priority requester (port A, CPU side) and a secondary requester (port B, video/DMA side). It issues at most one SRAM access per cycle. Port A has fixed priority, bounded by a starvation counter that guarantees port B a slot. Each port's read data is returned with a valid strobe and held in a per-port register. The block sits directly in front of the SRAM instance and drives all of its control inputs.

---
 rtl/sram_arbiter_65536x8.sv | 106 ++++++++++
 tb/tb_sram_arbiter_65536x8.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_65536x8.sv
// Two-port arbiter sharing one 65536x8 single-port synchronous SRAM.
// Port A has fixed priority; a starvation counter guarantees port B a slot.
module sram_arbiter_65536x8 #(
    parameter int B_MAX_WAIT = 3
) (
    input  logic        sram_clock,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_read_not_write,
    input  logic [15:0] a_address,
    input  logic [7:0]  a_write_data,
    output logic        a_ack,
    output logic        a_rdata_valid,
    output logic [7:0]  a_read_data,
    input  logic        b_req,
    input  logic        b_read_not_write,
    input  logic [15:0] b_address,
    input  logic [7:0]  b_write_data,
    output logic        b_ack,
    output logic        b_rdata_valid,
    output logic [7:0]  b_read_data,
    output logic        sram_select,
    output logic        sram_read_not_write,
    output logic        sram_write_enable,
    output logic [15:0] sram_address,
    output logic [7:0]  sram_write_data,
    input  logic [7:0]  sram_data_out
);

    localparam logic [3:0] MAX_WAIT = 4'(B_MAX_WAIT);

    logic [3:0] wait_count;
    logic       rd_pend_a;
    logic       rd_pend_b;
    logic       grant_a;
    logic       grant_b;

    // B wins a contested cycle only once it has been refused MAX_WAIT times.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                if (wait_count == MAX_WAIT)
                    grant_b = 1'b1;
                else
                    grant_a = 1'b1;
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;

    always_comb begin
        sram_select         = 1'b0;
        sram_read_not_write = 1'b1;
        sram_write_enable   = 1'b0;
        sram_address        = 16'h0000;
        sram_write_data     = 8'h00;
        if (grant_a) begin
            sram_select         = 1'b1;
            sram_read_not_write = a_read_not_write;
            sram_write_enable   = !a_read_not_write;
            sram_address        = a_address;
            sram_write_data     = a_write_data;
        end else if (grant_b) begin
            sram_select         = 1'b1;
            sram_read_not_write = b_read_not_write;
            sram_write_enable   = !b_read_not_write;
            sram_address        = b_address;
            sram_write_data     = b_write_data;
        end
    end

    // The SRAM registers its output, so read data is captured one cycle after the pend flag.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            wait_count    <= 4'd0;
            rd_pend_a     <= 1'b0;
            rd_pend_b     <= 1'b0;
            a_rdata_valid <= 1'b0;
            b_rdata_valid <= 1'b0;
            a_read_data   <= 8'h00;
            b_read_data   <= 8'h00;
        end else begin
            if (grant_b || !b_req)
                wait_count <= 4'd0;
            else if (grant_a && wait_count != MAX_WAIT)
                wait_count <= wait_count + 4'd1;
            rd_pend_a     <= grant_a && a_read_not_write;
            rd_pend_b     <= grant_b && b_read_not_write;
            a_rdata_valid <= rd_pend_a;
            b_rdata_valid <= rd_pend_b;
            if (rd_pend_a)
                a_read_data <= sram_data_out;
            if (rd_pend_b)
                b_read_data <= sram_data_out;
        end
    end

endmodule

// File: tb/tb_sram_arbiter_65536x8.sv
// Table-driven bench for sram_arbiter_65536x8 with a behavioural registered-output SRAM.
module tb_sram_arbiter_65536x8;

    logic        sram_clock = 1'b0;
    logic        reset;
    logic        a_req, a_read_not_write, b_req, b_read_not_write;
    logic [15:0] a_address, b_address;
    logic [7:0]  a_write_data, b_write_data;
    logic        a_ack, a_rdata_valid, b_ack, b_rdata_valid;
    logic [7:0]  a_read_data, b_read_data;
    logic        sram_select, sram_read_not_write, sram_write_enable;
    logic [15:0] sram_address;
    logic [7:0]  sram_write_data, sram_data_out;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mem [0:65535];

    always #5 sram_clock = ~sram_clock;

    sram_arbiter_65536x8 #(.B_MAX_WAIT(3)) dut (
        .sram_clock(sram_clock), .reset(reset),
        .a_req(a_req), .a_read_not_write(a_read_not_write), .a_address(a_address),
        .a_write_data(a_write_data), .a_ack(a_ack), .a_rdata_valid(a_rdata_valid),
        .a_read_data(a_read_data),
        .b_req(b_req), .b_read_not_write(b_read_not_write), .b_address(b_address),
        .b_write_data(b_write_data), .b_ack(b_ack), .b_rdata_valid(b_rdata_valid),
        .b_read_data(b_read_data),
        .sram_select(sram_select), .sram_read_not_write(sram_read_not_write),
        .sram_write_enable(sram_write_enable), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_data_out(sram_data_out)
    );

    // Behavioural SRAM: write on select+enable, registered read data.
    always @(posedge sram_clock) begin
        if (sram_select && sram_write_enable)
            mem[sram_address] <= sram_write_data;
        if (sram_select && sram_read_not_write)
            sram_data_out <= mem[sram_address];
    end

    typedef struct {
        logic        rst;
        logic        a_rq;
        logic        a_rnw;
        logic [15:0] a_ad;
        logic [7:0]  a_wd;
        logic        b_rq;
        logic        b_rnw;
        logic [15:0] b_ad;
        logic [7:0]  b_wd;
        logic        e_a_ack;
        logic        e_b_ack;
        logic        e_sel;
        logic        e_wen;
        logic [15:0] e_addr;
        logic        e_arv;
        logic [7:0]  e_ard;
        logic        e_brv;
        logic [7:0]  e_brd;
    } vec_t;

    vec_t vecs [$];

    task automatic check_output(input string name, input int row, input logic [15:0] actual,
                                input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, row, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset            = v.rst;
        a_req            = v.a_rq;
        a_read_not_write = v.a_rnw;
        a_address        = v.a_ad;
        a_write_data     = v.a_wd;
        b_req            = v.b_rq;
        b_read_not_write = v.b_rnw;
        b_address        = v.b_ad;
        b_write_data     = v.b_wd;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_read_not_write = 1'b1; a_address = 16'h0; a_write_data = 8'h0;
        b_req = 1'b0; b_read_not_write = 1'b1; b_address = 16'h0; b_write_data = 8'h0;

        // Fields: rst, A{req,rnw,addr,wdata}, B{req,rnw,addr,wdata},
        // expected {a_ack,b_ack,select,write_en,address, a_valid,a_data, b_valid,b_data}
        vecs.push_back('{1,1,1,16'h1234,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h00,0,8'h00});
        vecs.push_back('{1,1,0,16'h1234,8'h5A, 1,0,16'h0002,8'h77, 0,0,0,0,16'h0000, 0,8'h00,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h00,0,8'h00});
        vecs.push_back('{0,1,0,16'h1234,8'h5A, 0,1,16'h0000,8'h00, 1,0,1,1,16'h1234, 0,8'h00,0,8'h00});
        vecs.push_back('{0,1,1,16'h1234,8'h00, 0,1,16'h0000,8'h00, 1,0,1,0,16'h1234, 0,8'h00,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h00,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,8'h5A,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h5A,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 1,0,16'hFFFF,8'hC3, 0,1,1,1,16'hFFFF, 0,8'h5A,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 1,0,16'h0000,8'h3C, 0,1,1,1,16'h0000, 0,8'h5A,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 1,1,16'hFFFF,8'h00, 0,1,1,0,16'hFFFF, 0,8'h5A,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 1,1,16'h0000,8'h00, 0,1,1,0,16'h0000, 0,8'h5A,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h5A,1,8'hC3});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h5A,1,8'h3C});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h5A,0,8'h3C});
        vecs.push_back('{0,1,0,16'h0001,8'h11, 0,1,16'h0000,8'h00, 1,0,1,1,16'h0001, 0,8'h5A,0,8'h3C});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 1,0,16'h0002,8'h22, 0,1,1,1,16'h0002, 0,8'h5A,0,8'h3C});
        vecs.push_back('{0,1,1,16'h0001,8'h00, 0,1,16'h0000,8'h00, 1,0,1,0,16'h0001, 0,8'h5A,0,8'h3C});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 1,1,16'h0002,8'h00, 0,1,1,0,16'h0002, 0,8'h5A,0,8'h3C});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 1,8'h11,0,8'h3C});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h11,1,8'h22});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h11,0,8'h22});
        vecs.push_back('{0,1,1,16'h1234,8'h00, 0,1,16'h0000,8'h00, 1,0,1,0,16'h1234, 0,8'h11,0,8'h22});
        vecs.push_back('{1,1,1,16'h1234,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h11,0,8'h22});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h00,0,8'h00});
        vecs.push_back('{0,0,1,16'h0000,8'h00, 0,1,16'h0000,8'h00, 0,0,0,0,16'h0000, 0,8'h00,0,8'h00});

        foreach (vecs[i]) begin
            @(negedge sram_clock);
            apply_stimulus(vecs[i]);
            #1;
            check_output("a_ack",         i, 16'(a_ack),         16'(vecs[i].e_a_ack));
            check_output("b_ack",         i, 16'(b_ack),         16'(vecs[i].e_b_ack));
            check_output("sram_select",   i, 16'(sram_select),   16'(vecs[i].e_sel));
            check_output("sram_write_en", i, 16'(sram_write_enable), 16'(vecs[i].e_wen));
            check_output("sram_address",  i, sram_address,       vecs[i].e_addr);
            check_output("a_rdata_valid", i, 16'(a_rdata_valid), 16'(vecs[i].e_arv));
            check_output("a_read_data",   i, 16'(a_read_data),   16'(vecs[i].e_ard));
            check_output("b_rdata_valid", i, 16'(b_rdata_valid), 16'(vecs[i].e_brv));
            check_output("b_read_data",   i, 16'(b_read_data),   16'(vecs[i].e_brd));
        end

        // Contention: both ports read continuously for 8 cycles; expect A,A,A,B,A,A,A,B.
        for (int k = 0; k < 10; k++) begin
            @(negedge sram_clock);
            reset = 1'b0;
            a_req = (k < 8); a_read_not_write = 1'b1; a_address = 16'h1234;
            b_req = (k < 8); b_read_not_write = 1'b1; b_address = 16'hFFFF;
            #1;
            check_output("contend_a_ack", 100 + k, 16'(a_ack), 16'(k < 8 && (k % 4) != 3));
            check_output("contend_b_ack", 100 + k, 16'(b_ack), 16'(k < 8 && (k % 4) == 3));
            check_output("contend_wait",  100 + k, 16'(dut.wait_count), 16'((k < 8) ? (k % 4) : 0));
            check_output("contend_a_rv",  100 + k, 16'(a_rdata_valid),
                         16'(k >= 2 && k < 10 && ((k - 2) % 4) != 3));
            check_output("contend_b_rv",  100 + k, 16'(b_rdata_valid), 16'(k == 5 || k == 9));
            if (k == 5)
                check_output("contend_b_data", 100 + k, 16'(b_read_data), 16'h00C3);
            if (k == 2)
                check_output("contend_a_data", 100 + k, 16'(a_read_data), 16'h005A);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
